alu_exec_unit: RTL and testbench
================================

// Module: alu_exec_unit
// PURPOSE
//  Parametrised, pipelined integer ALU functional unit for the Tomasulo core. Accepts one
//  op per cycle from the add/sub reservation stations. Ops are tagged with ROB, RS and
//  destination-register indices. Completed results queue in an output FIFO and broadcast
//  on the CDB under a valid/grant handshake, so the unit sustains LATENCY ops in flight
//  and stalls cleanly when the CDB is busy.
// PARAMETERS
//  DATA_W     8  operand/result width
//  ROB_W      3  ROB index width
//  RS_W       3  reservation-station index width
//  REG_W      4  architectural register index width
//  LATENCY    2  execute stages, >=1
//  OUT_DEPTH  4  result FIFO entries, >=LATENCY
// PORTS
//  clk1         in   1       clock, rising edge
//  rst          in   1       synchronous reset, active-high
//  issue_valid  in   1       RS presents an op
//  issue_ready  out  1       unit can accept an op this cycle
//  issue_func   in   4       opcode
//  issue_a      in   DATA_W  operand 1
//  issue_b      in   DATA_W  operand 2
//  issue_rob    in   ROB_W   ROB tag
//  issue_rs     in   RS_W    issuing RS entry
//  issue_rd     in   REG_W   destination register
//  flush        in   1       squash everything in flight (mispredict/exception)
//  cdb_valid    out  1       result presented on CDB
//  cdb_grant    in   1       CDB arbiter accepts the presented result
//  cdb_data     out  DATA_W  result
//  cdb_rob/rs/rd out ROB_W/RS_W/REG_W  tags of the presented result
//  cdb_exc      out  1       illegal opcode (data forced to 0)
//  busy         out  1       any op in pipe or FIFO
// BEHAVIOUR
//  - Reset: pipe valids and FIFO cleared. cdb_valid=0, cdb_* data/tags=0, cdb_exc=0, busy=0,
//    issue_ready=1. Reset overrides flush, issue and grant in the same cycle.
//  - Opcodes: 0000 add, 0001 sub (a-b), 0010 and, 0011 or, 0100 xor. All others set
//    exc=1 and data=0. add/sub wrap modulo 2^DATA_W.
//  - Accept: issue_valid&&issue_ready at an edge. Result computed in stage 1, then carried
//    through LATENCY stages. It is written to the FIFO at edge k+LATENCY. When the FIFO
//    is empty, cdb_valid rises in the cycle after edge k+LATENCY-1 (LATENCY cycles total).
//  - Credit rule: issue_ready = (pipe_occupancy + fifo_count) < OUT_DEPTH. Combinational,
//    registered terms only. FIFO never overflows and the pipe never stalls.
//  - CDB: FIFO head shown when cdb_valid=1. Outputs hold stable until cdb_grant. Pop on
//    valid&&grant. Grant without valid is ignored.
//  - Simultaneous pop and push keep fifo_count. Pointers wrap modulo OUT_DEPTH. Results
//    leave in issue order.
//  - Flush: at that edge, all pipe valids and the FIFO are cleared. An issue in the same
//    cycle is dropped. A grant in the same cycle is a no-op. cdb_valid=0 the next cycle.
//  - busy = any pipe valid || fifo_count!=0.
// CONFIGURATION
//  ALU_EXEC_SAT_EN defined: add/sub saturate as two's-complement signed
//    (clamp to 2^(DATA_W-1)-1 / -2^(DATA_W-1)). Logical ops are unchanged.
//  Undefined: add/sub wrap. No other difference, including latency.
// STRUCTURE
//  - Package tomasulo_pkg: opcode localparams (FUNC_ADD..FUNC_XOR) and a result struct/
//    typedef {data, rob, rs, rd, exc}, shared with RS and ROB blocks.
//  - Sub-module exec_result_fifo: parametrised synchronous FIFO (show-ahead, flush port).
//    ALU datapath and pipe registers stay inline.
// TESTING (defaults unless noted)
//  - add 0x05+0x03 rob=2 rd=4, grant held 1 -> cdb_valid 2 cycles after accept, data=0x08,
//    rob=2, rd=4, exc=0.
//  - sub 0x03-0x05 -> 0xFE when wrapping. With ALU_EXEC_SAT_EN, 0x7F+0x01 -> 0x7F and
//    0x80-0x01 -> 0x80.
//  - Back-to-back 6 issues, grant=0 -> issue_ready drops after 4 accepted. Head stable.
//    Grant each cycle then drains rob 0,1,2,3 in order and ready reasserts.
//  - Flush with 2 ops in pipe and 2 in FIFO, issue asserted same cycle -> next cycle
//    cdb_valid=0, busy=0, no later broadcast.
//  - func=1111 -> cdb_exc=1, data=0x00, tags passed through.
//  - rst asserted mid-stream with cdb_valid=1 -> all outputs at reset values next cycle.
//    LATENCY=4, OUT_DEPTH=4 rerun of the back-to-back test passes.

Source files
------------

// File: rtl/tomasulo_pkg.sv
// Shared definitions for the Tomasulo core: ALU opcodes, default field widths and the
// result record broadcast on the CDB. Imported by the ALU unit and the RS/ROB blocks.
// No ports (package).
package tomasulo_pkg;

    localparam logic [3:0] FUNC_ADD = 4'b0000;
    localparam logic [3:0] FUNC_SUB = 4'b0001;
    localparam logic [3:0] FUNC_AND = 4'b0010;
    localparam logic [3:0] FUNC_OR  = 4'b0011;
    localparam logic [3:0] FUNC_XOR = 4'b0100;

    localparam int DEF_DATA_W = 8;
    localparam int DEF_ROB_W  = 3;
    localparam int DEF_RS_W   = 3;
    localparam int DEF_REG_W  = 4;

    // CDB result record at the core's default widths.
    typedef struct packed {
        logic [DEF_DATA_W-1:0] data;
        logic [DEF_ROB_W-1:0]  rob;
        logic [DEF_RS_W-1:0]   rs;
        logic [DEF_REG_W-1:0]  rd;
        logic                  exc;
    } cdb_result_t;

endpackage

// File: rtl/exec_result_fifo.sv
// Synchronous show-ahead FIFO holding completed ALU results until the CDB takes them.
// Ports: clk1 clock; rst synchronous active-high reset; flush clears all entries;
//        push/push_data write; pop removes head; head is the oldest entry; count = entries.
// Pointers wrap modulo DEPTH, so DEPTH need not be a power of two.
module exec_result_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                       clk1,
    input  logic                       rst,
    input  logic                       flush,
    input  logic                       push,
    input  logic [WIDTH-1:0]           push_data,
    input  logic                       pop,
    output logic [WIDTH-1:0]           head,
    output logic [$clog2(DEPTH+1)-1:0] count
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] rd_ptr_q, wr_ptr_q;
    logic [CNT_W-1:0] count_q;
    logic             do_push, do_pop;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign do_pop  = pop && (count_q != '0);
    assign do_push = push && ((count_q != CNT_W'(DEPTH)) || do_pop);

    always_ff @(posedge clk1) begin
        if (rst || flush) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr_q] <= push_data;
                wr_ptr_q      <= ptr_inc(wr_ptr_q);
            end
            if (do_pop) begin
                rd_ptr_q <= ptr_inc(rd_ptr_q);
            end
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    assign head  = mem[rd_ptr_q];
    assign count = count_q;

endmodule

// File: rtl/alu_exec_unit.sv
// Pipelined integer ALU functional unit. One op per cycle enters from the add/sub RS, is
// computed in stage 1 and carried through LATENCY stages, then queued for the CDB.
// Ports: clk1/rst (sync, active-high); issue_* op + tags with valid/ready; flush squashes
//        everything in flight; cdb_* result + tags under cdb_valid/cdb_grant; busy.
// Build option: ALU_EXEC_SAT_EN makes add/sub saturate as signed; default is wrapping.
module alu_exec_unit
    import tomasulo_pkg::*;
#(
    parameter int DATA_W    = DEF_DATA_W,
    parameter int ROB_W     = DEF_ROB_W,
    parameter int RS_W      = DEF_RS_W,
    parameter int REG_W     = DEF_REG_W,
    parameter int LATENCY   = 2,
    parameter int OUT_DEPTH = 4
) (
    input  logic              clk1,
    input  logic              rst,
    input  logic              issue_valid,
    output logic              issue_ready,
    input  logic [3:0]        issue_func,
    input  logic [DATA_W-1:0] issue_a,
    input  logic [DATA_W-1:0] issue_b,
    input  logic [ROB_W-1:0]  issue_rob,
    input  logic [RS_W-1:0]   issue_rs,
    input  logic [REG_W-1:0]  issue_rd,
    input  logic              flush,
    output logic              cdb_valid,
    input  logic              cdb_grant,
    output logic [DATA_W-1:0] cdb_data,
    output logic [ROB_W-1:0]  cdb_rob,
    output logic [RS_W-1:0]   cdb_rs,
    output logic [REG_W-1:0]  cdb_rd,
    output logic              cdb_exc,
    output logic              busy
);
    localparam int RES_W = DATA_W + ROB_W + RS_W + REG_W + 1;
    localparam int CNT_W = $clog2(OUT_DEPTH + 1);
    localparam int OCC_W = $clog2(OUT_DEPTH + LATENCY + 1);

    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic [ROB_W-1:0]  rob;
        logic [RS_W-1:0]   rs;
        logic [REG_W-1:0]  rd;
        logic              exc;
    } exec_res_t;

    logic [DATA_W-1:0] add_res, sub_res;
    exec_res_t         new_res;

`ifdef ALU_EXEC_SAT_EN
    logic [DATA_W:0] add_ext, sub_ext;

    // Sign-extended result disagreeing in its top two bits means signed overflow.
    function automatic logic [DATA_W-1:0] sat_clamp(input logic [DATA_W:0] x);
        logic [DATA_W-1:0] r;
        if (x[DATA_W] != x[DATA_W-1]) r = {x[DATA_W], {(DATA_W-1){~x[DATA_W]}}};
        else                          r = x[DATA_W-1:0];
        return r;
    endfunction

    assign add_ext = {issue_a[DATA_W-1], issue_a} + {issue_b[DATA_W-1], issue_b};
    assign sub_ext = {issue_a[DATA_W-1], issue_a} - {issue_b[DATA_W-1], issue_b};
    assign add_res = sat_clamp(add_ext);
    assign sub_res = sat_clamp(sub_ext);
`else
    assign add_res = issue_a + issue_b;
    assign sub_res = issue_a - issue_b;
`endif

    always_comb begin
        new_res      = '0;
        new_res.rob  = issue_rob;
        new_res.rs   = issue_rs;
        new_res.rd   = issue_rd;
        case (issue_func)
            FUNC_ADD: new_res.data = add_res;
            FUNC_SUB: new_res.data = sub_res;
            FUNC_AND: new_res.data = issue_a & issue_b;
            FUNC_OR:  new_res.data = issue_a | issue_b;
            FUNC_XOR: new_res.data = issue_a ^ issue_b;
            default:  new_res.exc  = 1'b1;
        endcase
    end

    logic              accept;
    logic [LATENCY-1:0] pipe_vld_q;
    exec_res_t         pipe_res_q [LATENCY];
    logic [OCC_W-1:0]  pipe_cnt;
    logic [CNT_W-1:0]  fifo_count;
    logic [RES_W-1:0]  fifo_head;
    exec_res_t         head_res, last_res, shown;
    logic              last_vld, fifo_empty, granted, fifo_push, fifo_pop;

    assign accept = issue_valid && issue_ready && !flush;

    always_ff @(posedge clk1) begin
        if (rst || flush) begin
            pipe_vld_q <= '0;
        end else begin
            pipe_vld_q[0] <= accept;
            for (int i = 1; i < LATENCY; i++) begin
                pipe_vld_q[i] <= pipe_vld_q[i-1];
            end
        end
    end

    // Payload needs no reset: it is only observed alongside its valid bit.
    always_ff @(posedge clk1) begin
        pipe_res_q[0] <= new_res;
        for (int i = 1; i < LATENCY; i++) begin
            pipe_res_q[i] <= pipe_res_q[i-1];
        end
    end

    always_comb begin
        pipe_cnt = '0;
        for (int i = 0; i < LATENCY; i++) begin
            pipe_cnt = pipe_cnt + OCC_W'(pipe_vld_q[i]);
        end
    end

    // Every op in flight holds a FIFO credit, so the pipe never has to stall.
    assign issue_ready = (pipe_cnt + OCC_W'(fifo_count)) < OCC_W'(OUT_DEPTH);

    assign last_vld   = pipe_vld_q[LATENCY-1];
    assign last_res   = pipe_res_q[LATENCY-1];
    assign fifo_empty = (fifo_count == '0);
    assign head_res   = fifo_head;

    // With an empty FIFO the last stage drives the CDB directly; if not granted it is
    // pushed and reappears unchanged as the FIFO head.
    assign shown     = fifo_empty ? last_res : head_res;
    assign cdb_valid = !fifo_empty || last_vld;
    assign granted   = cdb_valid && cdb_grant && !flush;
    assign fifo_pop  = granted && !fifo_empty;
    assign fifo_push = last_vld && !(granted && fifo_empty);

    exec_result_fifo #(
        .WIDTH (RES_W),
        .DEPTH (OUT_DEPTH)
    ) u_fifo (
        .clk1      (clk1),
        .rst       (rst),
        .flush     (flush),
        .push      (fifo_push),
        .push_data (last_res),
        .pop       (fifo_pop),
        .head      (fifo_head),
        .count     (fifo_count)
    );

    assign cdb_data = cdb_valid ? shown.data : '0;
    assign cdb_rob  = cdb_valid ? shown.rob  : '0;
    assign cdb_rs   = cdb_valid ? shown.rs   : '0;
    assign cdb_rd   = cdb_valid ? shown.rd   : '0;
    assign cdb_exc  = cdb_valid && shown.exc;
    assign busy     = (|pipe_vld_q) || !fifo_empty;

endmodule

// File: tb/tb_alu_exec_unit.sv
module tb_alu_exec_unit;
    import tomasulo_pkg::*;

    localparam int DW  = 8;
    localparam int RW  = 3;
    localparam int SW  = 3;
    localparam int GW  = 4;
    localparam int LAT = 2;
    localparam int DEP = 4;

    logic clk1 = 1'b0;
    always #5 clk1 = ~clk1;

    logic          rst = 1'b1;
    logic          issue_valid = 1'b0, issue_ready;
    logic [3:0]    issue_func = '0;
    logic [DW-1:0] issue_a = '0, issue_b = '0;
    logic [RW-1:0] issue_rob = '0;
    logic [SW-1:0] issue_rs = '0;
    logic [GW-1:0] issue_rd = '0;
    logic          flush = 1'b0;
    logic          cdb_valid, cdb_grant = 1'b0, cdb_exc, busy;
    logic [DW-1:0] cdb_data;
    logic [RW-1:0] cdb_rob;
    logic [SW-1:0] cdb_rs;
    logic [GW-1:0] cdb_rd;

    alu_exec_unit #(
        .DATA_W(DW), .ROB_W(RW), .RS_W(SW), .REG_W(GW), .LATENCY(LAT), .OUT_DEPTH(DEP)
    ) dut (
        .clk1(clk1), .rst(rst), .issue_valid(issue_valid), .issue_ready(issue_ready),
        .issue_func(issue_func), .issue_a(issue_a), .issue_b(issue_b),
        .issue_rob(issue_rob), .issue_rs(issue_rs), .issue_rd(issue_rd), .flush(flush),
        .cdb_valid(cdb_valid), .cdb_grant(cdb_grant), .cdb_data(cdb_data),
        .cdb_rob(cdb_rob), .cdb_rs(cdb_rs), .cdb_rd(cdb_rd), .cdb_exc(cdb_exc), .busy(busy)
    );

    // Second instance with a deeper pipe, driven by a short directed sequence.
    logic          v4 = 1'b0, g4 = 1'b0, f4 = 1'b0, rdy4, val4, exc4, busy4;
    logic [DW-1:0] a4 = '0, d4;
    logic [RW-1:0] rob4 = '0, crob4;
    logic [SW-1:0] crs4;
    logic [GW-1:0] crd4;

    alu_exec_unit #(
        .DATA_W(DW), .ROB_W(RW), .RS_W(SW), .REG_W(GW), .LATENCY(4), .OUT_DEPTH(4)
    ) dut4 (
        .clk1(clk1), .rst(rst), .issue_valid(v4), .issue_ready(rdy4),
        .issue_func(FUNC_ADD), .issue_a(a4), .issue_b(8'h01),
        .issue_rob(rob4), .issue_rs(3'd0), .issue_rd(4'd0), .flush(f4),
        .cdb_valid(val4), .cdb_grant(g4), .cdb_data(d4),
        .cdb_rob(crob4), .cdb_rs(crs4), .cdb_rd(crd4), .cdb_exc(exc4), .busy(busy4)
    );

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    always @(posedge clk1) cyc <= cyc + 1;

    typedef struct {
        logic [DW-1:0] data;
        logic [RW-1:0] rob;
        logic [SW-1:0] rs;
        logic [GW-1:0] rd;
        logic          exc;
        int            acc;   // edge at which the op is accepted
    } exp_t;

    exp_t sb[$];
    bit   mon_en = 1'b0;
    bit   acc_bit;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Reference ALU: {exc, data} from plain signed integer arithmetic.
    function automatic logic [DW:0] ref_alu(input logic [3:0] f, input logic [DW-1:0] a,
                                            input logic [DW-1:0] b);
        int sav, sbv, r, maxv, minv;
        logic [DW-1:0] d;
        maxv = (1 << (DW - 1)) - 1;
        minv = -(1 << (DW - 1));
        sav  = a[DW-1] ? int'(a) - (1 << DW) : int'(a);
        sbv  = b[DW-1] ? int'(b) - (1 << DW) : int'(b);
        case (f)
            FUNC_ADD: r = sav + sbv;
            FUNC_SUB: r = sav - sbv;
            FUNC_AND: return {1'b0, a & b};
            FUNC_OR:  return {1'b0, a | b};
            FUNC_XOR: return {1'b0, a ^ b};
            default:  return {1'b1, {DW{1'b0}}};
        endcase
`ifdef ALU_EXEC_SAT_EN
        if (r > maxv) r = maxv;
        if (r < minv) r = minv;
`endif
        d = r[DW-1:0];
        return {1'b0, d};
    endfunction

    // One cycle of stimulus, entered and left 1ns after a rising edge.
    task automatic step(input logic v, input logic [3:0] f, input logic [DW-1:0] a,
                        input logic [DW-1:0] b, input logic [RW-1:0] rob,
                        input logic [SW-1:0] rs, input logic [GW-1:0] rd,
                        input logic g, input logic fl, input logic r, output bit accepted);
        logic      exp_ready;
        logic [DW:0] res;
        exp_t      e;
        issue_valid = v; issue_func = f; issue_a = a; issue_b = b;
        issue_rob = rob; issue_rs = rs; issue_rd = rd;
        cdb_grant = g; flush = fl; rst = r;
        exp_ready = (sb.size() < DEP);
        check("issue_ready", 32'(issue_ready), 32'(exp_ready));
        accepted = v && exp_ready && !fl && !r;
        if (accepted) begin
            res   = ref_alu(f, a, b);
            e.data = res[DW-1:0];
            e.exc  = res[DW];
            e.rob  = rob; e.rs = rs; e.rd = rd;
            e.acc  = cyc + 1;
            sb.push_back(e);
        end
        @(posedge clk1);
        #1;
        if (fl || r) sb.delete();
    endtask

    task automatic idle(input logic g);
        bit unused_acc;
        step(1'b0, 4'd0, '0, '0, '0, '0, '0, g, 1'b0, 1'b0, unused_acc);
    endtask

    // Monitor: checks presentation timing and pops the scoreboard on each handshake.
    initial begin
        logic exp_valid;
        int   n_in;
        forever begin
            @(negedge clk1);
            if (mon_en) begin
                n_in = 0;
                foreach (sb[i]) if (sb[i].acc <= cyc) n_in++;
                exp_valid = (sb.size() > 0) && (cyc >= sb[0].acc + LAT - 1);
                check("cdb_valid", 32'(cdb_valid), 32'(exp_valid));
                check("busy", 32'(busy), 32'(n_in != 0));
                if (cdb_valid && exp_valid) begin
                    check("cdb_data", 32'(cdb_data), 32'(sb[0].data));
                    check("cdb_rob",  32'(cdb_rob),  32'(sb[0].rob));
                    check("cdb_rs",   32'(cdb_rs),   32'(sb[0].rs));
                    check("cdb_rd",   32'(cdb_rd),   32'(sb[0].rd));
                    check("cdb_exc",  32'(cdb_exc),  32'(sb[0].exc));
                    if (cdb_grant && !flush && !rst) void'(sb.pop_front());
                end
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int nacc, idx;
        bit took;
        logic [3:0] rf;

        @(posedge clk1);
        #1;
        step(1'b0, 4'd0, '0, '0, '0, '0, '0, 1'b0, 1'b0, 1'b1, acc_bit);
        step(1'b0, 4'd0, '0, '0, '0, '0, '0, 1'b1, 1'b0, 1'b1, acc_bit);

        // Reset state
        check("rst_cdb_valid", 32'(cdb_valid), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_issue_ready", 32'(issue_ready), 32'd1);
        check("rst_cdb_data", 32'(cdb_data), 32'd0);
        check("rst_cdb_tags", 32'({cdb_rob, cdb_rs, cdb_rd}), 32'd0);
        check("rst_cdb_exc", 32'(cdb_exc), 32'd0);
        mon_en = 1'b1;

        // add 5+3, grant held: visible LATENCY cycles after acceptance
        step(1'b1, FUNC_ADD, 8'h05, 8'h03, 3'd2, 3'd1, 4'd4, 1'b1, 1'b0, 1'b0, acc_bit);
        check("add_not_yet_valid", 32'(cdb_valid), 32'd0);
        idle(1'b1);
        check("add_valid", 32'(cdb_valid), 32'd1);
        check("add_data", 32'(cdb_data), 32'h08);
        check("add_rob", 32'(cdb_rob), 32'd2);
        check("add_rd", 32'(cdb_rd), 32'd4);
        check("add_exc", 32'(cdb_exc), 32'd0);
        repeat (3) idle(1'b1);

        // sub wrap / saturation corners and an illegal opcode
        step(1'b1, FUNC_SUB, 8'h03, 8'h05, 3'd1, 3'd2, 4'd3, 1'b1, 1'b0, 1'b0, acc_bit);
        step(1'b1, FUNC_ADD, 8'h7F, 8'h01, 3'd3, 3'd0, 4'd1, 1'b1, 1'b0, 1'b0, acc_bit);
        step(1'b1, FUNC_SUB, 8'h80, 8'h01, 3'd4, 3'd1, 4'd2, 1'b1, 1'b0, 1'b0, acc_bit);
        step(1'b1, 4'b1111, 8'h55, 8'hAA, 3'd5, 3'd6, 4'd9, 1'b1, 1'b0, 1'b0, acc_bit);
        repeat (4) idle(1'b1);

        // Back-to-back issues against a stalled CDB
        nacc = 0;
        for (int i = 0; i < 6; i++) begin
            step(1'b1, FUNC_ADD, 8'(nacc), 8'h10, 3'(nacc), 3'd1, 4'd5, 1'b0, 1'b0, 1'b0,
                 acc_bit);
            nacc += int'(acc_bit);
        end
        check("b2b_accepted", 32'(nacc), 32'd4);
        check("b2b_ready_low", 32'(issue_ready), 32'd0);
        repeat (3) idle(1'b0);
        repeat (10) idle(1'b1);
        check("b2b_ready_back", 32'(issue_ready), 32'd1);
        check("b2b_drained", 32'(busy), 32'd0);

        // Flush with two ops in the pipe and two in the FIFO, issue in the same cycle
        for (int i = 0; i < 4; i++) begin
            step(1'b1, FUNC_XOR, 8'($urandom), 8'($urandom), 3'(i), 3'd2, 4'd6, 1'b0, 1'b0,
                 1'b0, acc_bit);
        end
        step(1'b1, FUNC_OR, 8'h0F, 8'hF0, 3'd7, 3'd7, 4'd7, 1'b1, 1'b1, 1'b0, acc_bit);
        check("flush_cdb_valid", 32'(cdb_valid), 32'd0);
        check("flush_busy", 32'(busy), 32'd0);
        repeat (5) idle(1'b1);

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            rf = ($urandom_range(0, 4) != 0) ? 4'($urandom_range(0, 4))
                                             : 4'($urandom_range(5, 15));
            step(($urandom_range(0, 9) < 7), rf, 8'($urandom), 8'($urandom), 3'($urandom),
                 3'($urandom), 4'($urandom), ($urandom_range(0, 9) < 6),
                 ($urandom_range(0, 59) == 0), 1'b0, acc_bit);
        end
        repeat (8) idle(1'b1);

        // Reset mid-stream while a result is presented
        step(1'b1, FUNC_AND, 8'hF3, 8'h3C, 3'd1, 3'd1, 4'd1, 1'b0, 1'b0, 1'b0, acc_bit);
        step(1'b1, FUNC_ADD, 8'h11, 8'h22, 3'd2, 3'd2, 4'd2, 1'b0, 1'b0, 1'b0, acc_bit);
        for (int i = 0; i < 20 && !cdb_valid; i++) idle(1'b0);
        check("pre_reset_valid", 32'(cdb_valid), 32'd1);
        step(1'b1, FUNC_ADD, 8'h01, 8'h01, 3'd3, 3'd3, 4'd3, 1'b1, 1'b1, 1'b1, acc_bit);
        check("mid_rst_cdb_valid", 32'(cdb_valid), 32'd0);
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_ready", 32'(issue_ready), 32'd1);
        check("mid_rst_outputs", 32'({cdb_data, cdb_rob, cdb_rs, cdb_rd, cdb_exc}), 32'd0);
        repeat (4) idle(1'b1);
        mon_en = 1'b0;

        // LATENCY=4, OUT_DEPTH=4: back-to-back against a stalled CDB, then drain
        nacc = 0;
        for (int i = 0; i < 6; i++) begin
            v4 = 1'b1; rob4 = 3'(nacc); a4 = 8'(nacc);
            took = rdy4;
            @(posedge clk1);
            #1;
            if (took) nacc++;
        end
        v4 = 1'b0;
        check("lat4_accepted", 32'(nacc), 32'd4);
        check("lat4_ready_low", 32'(rdy4), 32'd0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk1);
            check("lat4_head_valid", 32'(val4), 32'd1);
            check("lat4_head_rob", 32'(crob4), 32'd0);
            check("lat4_head_data", 32'(d4), 32'h01);
            @(posedge clk1);
            #1;
        end
        g4 = 1'b1;
        idx = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk1);
            if (val4) begin
                check("lat4_drain_rob", 32'(crob4), 32'(idx));
                check("lat4_drain_data", 32'(d4), 32'(idx + 1));
                idx++;
            end
            @(posedge clk1);
            #1;
        end
        check("lat4_drain_count", 32'(idx), 32'd4);
        check("lat4_ready_back", 32'(rdy4), 32'd1);
        check("lat4_idle", 32'(busy4), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
